// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared ULA widths, divider state encoding and divide-by-zero constant
package ula_pkg;

  localparam int ULA_A_W   = 8;
  localparam int ULA_RES_W = 16;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  localparam logic [ULA_RES_W-1:0] DIV_BY_ZERO_QUO = 16'hFFFF;

endpackage

// File: rtl/ula_div_step.sv
// rtl/ula_div_step.sv - one combinational restoring-division iteration
module ula_div_step
  import ula_pkg::*;
#(
  parameter int DIVISOR_W = ULA_A_W
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 quo_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] rem_shift;
  logic [DIVISOR_W:0] trial;
  logic               fits;

  // Shift in the next dividend bit, trial-subtract, and restore when the divisor does not fit.
  // rem_in is always below the divisor, so its top bit only participates in the fit test.
  always_comb begin
    rem_shift = {rem_in[DIVISOR_W-1:0], quo_msb};
    fits      = {rem_in, quo_msb} >= {2'b00, divisor};
    trial     = rem_shift - {1'b0, divisor};
    rem_out   = fits ? trial : rem_shift;
    q_bit     = fits;
  end

endmodule

// File: rtl/ula_divider.sv
// rtl/ula_divider.sv - sequential restoring divider with start/busy/done handshake and ULA flags
module ula_divider
  import ula_pkg::*;
#(
  parameter int DIVIDEND_W = ULA_RES_W,
  parameter int DIVISOR_W  = ULA_A_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  zero_flag,
  output logic                  sign_flag,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  div_state_t state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  zero_q, zero_d;
  logic                  sign_q, sign_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  ula_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (rem_q),
    .quo_msb (quo_q[DIVIDEND_W-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state and datapath: operand capture in IDLE, one iteration per RUN cycle,
  // result/flag registers written only on the transition into DONE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    sign_d      = sign_q;
    dbz_d       = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          dvsr_d = divisor;
          if (divisor == '0) begin
            state_d     = DIV_DONE;
            quotient_d  = DIV_BY_ZERO_QUO[DIVIDEND_W-1:0];
            remainder_d = dividend[DIVISOR_W-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = DIV_RUN;
            rem_d   = '0;
            quo_d   = dividend;
            count_d = '0;
          end
        end
      end
      DIV_RUN: begin
        rem_d   = step_rem;
        quo_d   = {quo_q[DIVIDEND_W-2:0], step_q};
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d     = DIV_DONE;
          quotient_d  = {quo_q[DIVIDEND_W-2:0], step_q};
          remainder_d = step_rem[DIVISOR_W-1:0];
          dbz_d       = 1'b0;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (state_q != DIV_DONE && state_d == DIV_DONE) begin
      zero_d = (quotient_d == '0);
      sign_d = quotient_d[DIVIDEND_W-1];
    end

    busy_d = (state_d != DIV_IDLE);
    done_d = (state_d == DIV_DONE);
  end

  // State, datapath and output registers; reset aborts any operation and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign zero_flag   = zero_q;
  assign sign_flag   = sign_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ula_divider.sv
// tb/tb_ula_divider.sv - directed self-checking bench for ula_divider
module tb_ula_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        zero_flag;
  logic        sign_flag;
  logic        div_by_zero;

  int n_checks = 0;
  int n_passed = 0;
  logic [15:0] last_quo = 16'h0000;

  ula_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .zero_flag   (zero_flag),
    .sign_flag   (sign_flag),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Launch one operation; optionally pulse start (50/5) at cycles p1/p2 after acceptance.
  task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic ez,
                        input logic es, input logic edbz, input int elat,
                        input int p1, input int p2);
    int lat;
    int ndone;
    lat = 0;
    ndone = 0;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        if (elat > 1) check({name, "_held"}, {16'd0, quotient}, {16'd0, last_quo});
      end
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      if (k == p1 || k == p2) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
    check({name, "_lat"}, lat, elat);
    check({name, "_ndone"}, ndone, 1);
    check({name, "_quo"}, {16'd0, quotient}, {16'd0, eq});
    check({name, "_rem"}, {24'd0, remainder}, {24'd0, er});
    check({name, "_flags"}, {29'd0, zero_flag, sign_flag, div_by_zero}, {29'd0, ez, es, edbz});
    check({name, "_idle"}, {30'd0, busy, done}, 32'd0);
    last_quo = eq;
  endtask

  initial begin
    int ndone;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {quotient, remainder, zero_flag, sign_flag, div_by_zero, busy, done, 3'd0},
          32'd0);
    rst_n = 1'b1;

    run_op("d1000_7",   16'd1000,  8'd7,   16'h008E, 8'd6,  1'b0, 1'b0, 1'b0, 17, 0, 0);
    run_op("dffff_1",   16'hFFFF,  8'd1,   16'hFFFF, 8'd0,  1'b0, 1'b1, 1'b0, 17, 0, 0);
    run_op("dffff_ff",  16'hFFFF,  8'hFF,  16'h0101, 8'd0,  1'b0, 1'b0, 1'b0, 17, 0, 0);
    run_op("d5_10",     16'd5,     8'd10,  16'h0000, 8'd5,  1'b1, 1'b0, 1'b0, 17, 0, 0);
    run_op("d0_3",      16'd0,     8'd3,   16'h0000, 8'd0,  1'b1, 1'b0, 1'b0, 17, 0, 0);
    run_op("d1234_0",   16'h1234,  8'd0,   16'hFFFF, 8'h34, 1'b0, 1'b1, 1'b1, 1,  0, 0);
    run_op("d9_3",      16'd9,     8'd3,   16'h0003, 8'd0,  1'b0, 1'b0, 1'b0, 17, 0, 0);
    run_op("d100_9ign", 16'd100,   8'd9,   16'h000B, 8'd1,  1'b0, 1'b0, 1'b0, 17, 3, 17);

    // Reset in the middle of a run: outputs clear asynchronously, no done pulse.
    ndone = 0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {quotient, remainder, zero_flag, sign_flag, div_by_zero, busy, done, 3'd0},
          32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid_nodone", ndone, 0);
    last_quo = 16'h0000;

    run_op("d200_8",    16'd200,   8'd8,   16'd25,   8'd0,  1'b0, 1'b0, 1'b0, 17, 0, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
